// File: rtl/tdm_demux_pkg.sv
// Shared types and frame geometry for the two-channel TDM demultiplexer.
// TDM_DEMUX_PARITY_EN adds one even-parity beat per channel to each frame.
package tdm_demux_pkg;

    typedef enum logic {StHunt, StRun} state_e;
    typedef enum logic {SlotCh0, SlotCh1} slot_e;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned ParBits = 1;
`else
    localparam int unsigned ParBits = 0;
`endif

    // Valid beats per frame: both channels interleaved, plus optional parity beats.
    function automatic int unsigned frame_beats(input int unsigned width);
        return 2 * (width + ParBits);
    endfunction

endpackage

// File: rtl/tdm_deser_shift.sv
// MSB-first deserializing shift register for one TDM channel.
// TDM_DEMUX_PARITY_EN adds a running even-parity accumulator.
module tdm_deser_shift #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             bit_i,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic             par_beat_i,
    output logic             par_nxt_o,
`endif
    output logic [Width-1:0] word_nxt_o
);

    logic [Width-1:0] word_q, word_d, word_base;
    logic             data_shift;

`ifdef TDM_DEMUX_PARITY_EN
    logic par_q, par_d;

    assign data_shift = shift_i && !par_beat_i;

    // Parity bit and data bits all fold in; a clean channel ends at zero.
    always_comb begin
        par_d = clr_i ? 1'b0 : par_q;
        if (shift_i) begin
            par_d = par_d ^ bit_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_nxt_o = par_d;
`else
    assign data_shift = shift_i;
`endif

    always_comb begin
        word_base = clr_i ? '0 : word_q;
        word_d    = word_base;
        if (data_shift) begin
            word_d = {word_base[Width-2:0], bit_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_nxt_o = word_d;

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer: locks to frame_sync, deserializes ch0/ch1 words.
// TDM_DEMUX_PARITY_EN adds per-channel even-parity beats and par_err0/par_err1 outputs.
module tdm_demux2
    import tdm_demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             out_valid,
    output logic             sync_err,
    output logic             locked
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic             par_err0,
    output logic             par_err1
`endif
);

    localparam int unsigned FrameBeats = frame_beats(WIDTH);
    localparam int unsigned CntW       = $clog2(FrameBeats);
    localparam logic [CntW-1:0] LastBeat = CntW'(FrameBeats - 1);

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] out0_q, out1_q;
    logic             out_valid_q, sync_err_q;

    slot_e            slot;
    logic             run_beat, start, misplaced, missing, data_beat, last_beat;
    logic             shift0, shift1;
    logic [WIDTH-1:0] word_nxt0, word_nxt1;

    always_comb begin
        slot      = slot_e'(cnt_q[0]);
        run_beat  = (state_q == StRun) && din_valid;
        // A marked beat always opens a new frame, whether hunting or mid-frame.
        start     = din_valid && frame_sync;
        misplaced = run_beat && frame_sync && (cnt_q != '0);
        missing   = run_beat && !frame_sync && (cnt_q == '0);
        data_beat = run_beat && !frame_sync && (cnt_q != '0);
        last_beat = data_beat && (cnt_q == LastBeat);
        shift0    = start || (data_beat && (slot == SlotCh0));
        shift1    = data_beat && (slot == SlotCh1);
    end

`ifdef TDM_DEMUX_PARITY_EN
    logic par_beat, par_nxt0, par_nxt1, par_err0_q, par_err1_q;

    assign par_beat = data_beat && (cnt_q >= CntW'(2 * WIDTH));
`endif

    tdm_deser_shift #(.Width(WIDTH)) u_ch0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (start),
        .shift_i    (shift0),
        .bit_i      (din),
`ifdef TDM_DEMUX_PARITY_EN
        .par_beat_i (par_beat),
        .par_nxt_o  (par_nxt0),
`endif
        .word_nxt_o (word_nxt0)
    );

    tdm_deser_shift #(.Width(WIDTH)) u_ch1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (start),
        .shift_i    (shift1),
        .bit_i      (din),
`ifdef TDM_DEMUX_PARITY_EN
        .par_beat_i (par_beat),
        .par_nxt_o  (par_nxt1),
`endif
        .word_nxt_o (word_nxt1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StHunt;
            cnt_q       <= '0;
            out0_q      <= '0;
            out1_q      <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err0_q  <= 1'b0;
            par_err1_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            if (start) begin
                state_q    <= StRun;
                cnt_q      <= CntW'(1);
                sync_err_q <= misplaced;
            end else if (missing) begin
                state_q    <= StHunt;
                sync_err_q <= 1'b1;
            end else if (last_beat) begin
                cnt_q       <= '0;
                out0_q      <= word_nxt0;
                out1_q      <= word_nxt1;
                out_valid_q <= 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                par_err0_q  <= par_nxt0;
                par_err1_q  <= par_nxt1;
`endif
            end else if (data_beat) begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign out0      = out0_q;
    assign out1      = out1_q;
    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;
    assign locked    = (state_q == StRun);
`ifdef TDM_DEMUX_PARITY_EN
    assign par_err0  = par_err0_q;
    assign par_err1  = par_err1_q;
`endif

endmodule

// File: tb/tb_tdm_demux2.sv
// Self-checking bench for tdm_demux2: queue-based frame model plus directed literal checks.
// Builds with or without TDM_DEMUX_PARITY_EN.
module tb_tdm_demux2;

    localparam int unsigned W = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned FB = 2 * (W + 1);
`else
    localparam int unsigned FB = 2 * W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         din = 1'b0;
    logic         din_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic [W-1:0] out0, out1;
    logic         out_valid, sync_err, locked;
`ifdef TDM_DEMUX_PARITY_EN
    logic         par_err0, par_err1;
`endif

    tdm_demux2 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .out0       (out0),
        .out1       (out1),
        .out_valid  (out_valid),
        .sync_err   (sync_err),
`ifdef TDM_DEMUX_PARITY_EN
        .par_err0   (par_err0),
        .par_err1   (par_err1),
`endif
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int sync_seen = 0;
    bit check_en = 1'b0;

    // Model: list of beats accepted since the current frame start.
    bit           q[$];
    logic [W-1:0] m_out0 = '0, m_out1 = '0;
    bit           m_ov = 1'b0, m_se = 1'b0, m_lock = 1'b0, m_pe0 = 1'b0, m_pe1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (sync_err === 1'b1) sync_seen++;
        m_ov = 1'b0;
        m_se = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_lock = 1'b0;
            m_out0 = '0;
            m_out1 = '0;
            m_pe0  = 1'b0;
            m_pe1  = 1'b0;
        end else if (din_valid) begin
            if (!m_lock) begin
                if (frame_sync) begin
                    q.delete();
                    q.push_back(din);
                    m_lock = 1'b1;
                end
            end else if (frame_sync) begin
                if (q.size() != 0) m_se = 1'b1;
                q.delete();
                q.push_back(din);
            end else if (q.size() == 0) begin
                m_se   = 1'b1;
                m_lock = 1'b0;
            end else begin
                q.push_back(din);
                if (q.size() == FB) begin
                    for (int i = 0; i < W; i++) begin
                        m_out0[W-1-i] = q[2*i];
                        m_out1[W-1-i] = q[2*i+1];
                    end
                    if (FB > 2 * W) begin
                        m_pe0 = (^m_out0) ^ q[2*W];
                        m_pe1 = (^m_out1) ^ q[2*W+1];
                    end
                    m_ov = 1'b1;
                    q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("out0", 32'(out0), 32'(m_out0));
            chk("out1", 32'(out1), 32'(m_out1));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("sync_err", 32'(sync_err), 32'(m_se));
            chk("locked", 32'(locked), 32'(m_lock));
`ifdef TDM_DEMUX_PARITY_EN
            if (m_ov) begin
                chk("par_err0", 32'(par_err0), 32'(m_pe0));
                chk("par_err1", 32'(par_err1), 32'(m_pe1));
            end
`endif
        end
    end

    task automatic beat(input bit d, input bit fs);
        din        = d;
        din_valid  = 1'b1;
        frame_sync = fs;
        @(negedge clk);
        din        = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // inj > 0 reasserts frame_sync on that beat; gap_a/gap_b insert 3 idle cycles after a beat.
    task automatic frame(input logic [W-1:0] a, input logic [W-1:0] b, input bit fs0,
                         input int inj, input int gap_a, input int gap_b, input bit rnd_gaps,
                         input bit bad_par1);
        bit d;
        for (int k = 0; k < FB; k++) begin
            if (k < 2 * W) d = (k % 2 == 0) ? a[W-1-k/2] : b[W-1-k/2];
            else if (k == 2 * W) d = ^a;
            else d = (^b) ^ bad_par1;
            beat(d, (k == 0 && fs0) || (k == inj && k != 0));
            if (k == gap_a || k == gap_b) idle(3);
            if (rnd_gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
    endtask

    initial begin
        int c0;
        int s0;
        int mode;
        int n;
        logic [W-1:0] a, b;

        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        check_en = 1'b1;
        chk("rst_out0", 32'(out0), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);

        // Basic contiguous frame.
        c0 = cyc;
        frame(8'hA5, 8'h3C, 1'b1, -1, -1, -1, 1'b0, 1'b0);
        chk("f1_out_valid", 32'(out_valid), 32'h1);
        chk("f1_out0", 32'(out0), 32'hA5);
        chk("f1_out1", 32'(out1), 32'h3C);
        chk("f1_locked", 32'(locked), 32'h1);
        chk("f1_latency", 32'(cyc - c0), 32'(FB));
        idle(1);
        chk("f1_pulse_len", 32'(out_valid), 32'h0);

        // Gaps after beats 4 and 11.
        c0 = cyc;
        frame(8'hA5, 8'h3C, 1'b1, -1, 4, 11, 1'b0, 1'b0);
        chk("gap_out_valid", 32'(out_valid), 32'h1);
        chk("gap_out0", 32'(out0), 32'hA5);
        chk("gap_latency", 32'(cyc - c0), 32'(FB + 6));

        // Marker reasserted on beat 6.
        s0 = sync_seen;
        for (int k = 0; k < 6; k++) beat(k[0], k == 0);
        frame(8'hFF, 8'h00, 1'b1, -1, -1, -1, 1'b0, 1'b0);
        idle(2);
        chk("mis_sync_cnt", 32'(sync_seen - s0), 32'h1);
        chk("mis_out0", 32'(out0), 32'hFF);
        chk("mis_out1", 32'(out1), 32'h00);

        // Missing marker after a good frame.
        frame(8'hA5, 8'h3C, 1'b1, -1, -1, -1, 1'b0, 1'b0);
        s0 = sync_seen;
        frame(8'h55, 8'hAA, 1'b0, -1, -1, -1, 1'b0, 1'b0);
        idle(2);
        chk("miss_sync_cnt", 32'(sync_seen - s0), 32'h1);
        chk("miss_locked", 32'(locked), 32'h0);
        chk("miss_out0", 32'(out0), 32'hA5);
        chk("miss_out1", 32'(out1), 32'h3C);

        // Reset mid-frame at beat 9.
        for (int k = 0; k < 9; k++) beat(1'b1, k == 0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("rstm_out0", 32'(out0), 32'h0);
        chk("rstm_out1", 32'(out1), 32'h0);
        chk("rstm_locked", 32'(locked), 32'h0);
        frame(8'h12, 8'h34, 1'b1, -1, -1, -1, 1'b0, 1'b0);
        chk("rstm_f_out0", 32'(out0), 32'h12);
        chk("rstm_f_out1", 32'(out1), 32'h34);

`ifdef TDM_DEMUX_PARITY_EN
        frame(8'hA5, 8'h3C, 1'b1, -1, -1, -1, 1'b0, 1'b1);
        chk("par_err0_lit", 32'(par_err0), 32'h0);
        chk("par_err1_lit", 32'(par_err1), 32'h1);
        chk("par_out1_lit", 32'(out1), 32'h3C);
`endif

        // Randomized frames with injected marker faults, resets and gaps.
        repeat (80) begin
            mode = $urandom_range(0, 9);
            a = W'($urandom);
            b = W'($urandom);
            case (mode)
                0: frame(a, b, 1'b0, -1, -1, -1, 1'b1, 1'b0);
                1: frame(a, b, 1'b1, $urandom_range(1, FB - 1), -1, -1, 1'b1, 1'b0);
                2: begin
                    n = $urandom_range(1, FB - 1);
                    for (int k = 0; k < n; k++) beat(1'($urandom_range(0, 1)), k == 0);
                    rst_n = 1'b0;
                    idle($urandom_range(1, 2));
                    rst_n = 1'b1;
                end
                3: frame(a, b, 1'b1, -1, -1, -1, 1'b1, 1'($urandom_range(0, 1)));
                default: frame(a, b, 1'b1, -1, -1, -1, mode[0], 1'b0);
            endcase
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
